// File: rtl/cpu_pkg.sv
// Shared opcode, state, select-code and flag definitions for the control unit.
// Optional CALL/RET support is enabled by defining CALL_RET_EN.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_IN   = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [3:0] {
        S_F1, S_F2, S_DEC, S_O1, S_O2, S_E1, S_E2, S_E3, S_E4, S_HALT
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_NOT = 3'd4;

    localparam logic [2:0] M1_GPR     = 3'd0;
    localparam logic [2:0] M1_ISR1    = 3'd1;
    localparam logic [2:0] M1_ISR2    = 3'd2;
    localparam logic [2:0] M1_ARGREG1 = 3'd3;
    localparam logic [2:0] M1_ARGREG2 = 3'd4;
    localparam logic [2:0] M1_PC      = 3'd5;
    localparam logic [2:0] M1_IR      = 3'd6;
    localparam logic [2:0] M1_SP      = 3'd7;

    localparam logic [1:0] M2_ALU  = 2'd0;
    localparam logic [1:0] M2_BUS1 = 2'd1;
    localparam logic [1:0] M2_RAM  = 2'd2;
    localparam logic [1:0] M2_ZERO = 2'd3;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;

    typedef struct packed {
        logic [3:0] load_r;
        logic [1:0] sel_read;
        logic [1:0] sel_write;
        logic       load_pc;
        logic       inc_pc;
        logic       load_ir;
        logic       load_add_r;
        logic       load_reg_y;
        logic       load_reg_z;
        logic       load_isr1;
        logic       load_isr2;
        logic       load_argreg1;
        logic       load_argreg2;
        logic       inc_sp;
        logic       dec_sp;
        logic       load_sp;
        logic [2:0] alu_select;
        logic [2:0] mux_1_sel;
        logic [1:0] mux_2_sel;
        logic       mem_write;
        logic       halted;
    } ctrl_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

    // ALU opcodes are contiguous and in the same order as the ALU select codes.
    function automatic logic [2:0] alu_code(input logic [3:0] op);
        return 3'(op - OP_ADD);
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational control-word decode from (state, opcode, rd, rs, zflag).
// CALL/RET states are decoded only when CALL_RET_EN is defined.
module cu_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic [1:0] rd,
    input  logic [1:0] rs,
    input  logic       zflag,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        if (state != S_HALT) ctrl.sel_write = rd;

        case (state)
            S_F1, S_O1: begin
                ctrl.mux_1_sel  = M1_PC;
                ctrl.mux_2_sel  = M2_BUS1;
                ctrl.load_add_r = 1'b1;
                ctrl.inc_pc     = 1'b1;
            end
            S_F2: begin
                ctrl.mux_2_sel = M2_RAM;
                ctrl.load_ir   = 1'b1;
            end
            S_O2: begin
                ctrl.mux_2_sel = M2_RAM;
                case (opcode)
                    OP_LDI:       ctrl.load_r     = 4'b0001 << rd;
                    OP_LD, OP_ST: ctrl.load_add_r = 1'b1;
                    OP_JMP:       ctrl.load_pc    = 1'b1;
                    // Not-taken JZ needs nothing: PC already skipped the operand in S_O1.
                    OP_JZ:        ctrl.load_pc    = zflag;
`ifdef CALL_RET_EN
                    OP_CALL:      ctrl.load_argreg1 = 1'b1;
`endif
                    default: ;
                endcase
            end
            S_E1: begin
                case (opcode)
                    OP_LD: begin
                        ctrl.mux_2_sel = M2_RAM;
                        ctrl.load_r    = 4'b0001 << rd;
                    end
                    OP_ST: begin
                        ctrl.mux_1_sel = M1_GPR;
                        ctrl.sel_read  = rs;
                        ctrl.mem_write = 1'b1;
                    end
                    OP_MOV: begin
                        ctrl.mux_1_sel = M1_GPR;
                        ctrl.sel_read  = rs;
                        ctrl.mux_2_sel = M2_BUS1;
                        ctrl.load_r    = 4'b0001 << rd;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: begin
                        ctrl.mux_1_sel  = M1_GPR;
                        ctrl.sel_read   = rd;
                        ctrl.mux_2_sel  = M2_BUS1;
                        ctrl.load_reg_y = 1'b1;
                    end
                    OP_IN: begin
                        ctrl.load_isr1 = ~rs[0];
                        ctrl.load_isr2 = rs[0];
                    end
`ifdef CALL_RET_EN
                    OP_CALL: ctrl.dec_sp = 1'b1;
                    OP_RET: begin
                        ctrl.mux_1_sel  = M1_SP;
                        ctrl.mux_2_sel  = M2_BUS1;
                        ctrl.load_add_r = 1'b1;
                        ctrl.inc_sp     = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            S_E2: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: begin
                        ctrl.mux_1_sel  = M1_GPR;
                        ctrl.sel_read   = rs;
                        ctrl.alu_select = alu_code(opcode);
                        ctrl.mux_2_sel  = M2_ALU;
                        ctrl.load_r     = 4'b0001 << rd;
                        ctrl.load_reg_z = 1'b1;
                    end
                    OP_IN: begin
                        ctrl.mux_1_sel = rs[0] ? M1_ISR2 : M1_ISR1;
                        ctrl.mux_2_sel = M2_BUS1;
                        ctrl.load_r    = 4'b0001 << rd;
                    end
`ifdef CALL_RET_EN
                    OP_CALL: begin
                        ctrl.mux_1_sel  = M1_SP;
                        ctrl.mux_2_sel  = M2_BUS1;
                        ctrl.load_add_r = 1'b1;
                    end
                    OP_RET: begin
                        ctrl.mux_2_sel = M2_RAM;
                        ctrl.load_pc   = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
`ifdef CALL_RET_EN
            S_E3: begin
                ctrl.mux_1_sel = M1_PC;
                ctrl.mem_write = 1'b1;
            end
            S_E4: begin
                ctrl.mux_1_sel = M1_ARGREG1;
                ctrl.mux_2_sel = M2_BUS1;
                ctrl.load_pc   = 1'b1;
            end
`endif
            S_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase

`ifdef CALL_RET_EN
        ctrl.load_sp = 1'b0;
`else
        ctrl.inc_sp  = 1'b0;
        ctrl.dec_sp  = 1'b0;
        ctrl.load_sp = 1'b0;
`endif
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: state register, zero flag and next-state logic.
// Define CALL_RET_EN to add the CALL (0xD) and RET (0xE) instructions.
module control_unit
    import cpu_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir_out,
    input  logic [7:0] alu_flags,
    output logic       load_R0,
    output logic       load_R1,
    output logic       load_R2,
    output logic       load_R3,
    output logic [1:0] gprf_sel_read,
    output logic [1:0] gprf_sel_write,
    output logic       load_PC,
    output logic       inc_PC,
    output logic       load_IR,
    output logic       load_Add_R,
    output logic       load_Reg_Y,
    output logic       load_Reg_Z,
    output logic       load_isr1,
    output logic       load_isr2,
    output logic       load_argreg1,
    output logic       load_argreg2,
    output logic       inc_SP,
    output logic       dec_SP,
    output logic       load_SP,
    output logic [2:0] alu_select,
    output logic [2:0] Mux_1_sel,
    output logic [1:0] Mux_2_sel,
    output logic       mem_write,
    output logic       halted
);

    state_t     state_q, state_d;
    logic       zflag_q, zflag_d;
    logic [3:0] opcode;
    ctrl_t      ctrl, ctrl_out;
    logic       unused_flags;

    assign opcode       = ir_out[7:4];
    assign unused_flags = ^alu_flags[7:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_F1;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zflag_q <= zflag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        zflag_d = zflag_q;
        case (state_q)
            S_F1: state_d = S_F2;
            S_F2: state_d = S_DEC;
            S_DEC: begin
                case (opcode)
                    OP_NOP:                                state_d = S_F1;
                    OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JZ:   state_d = S_O1;
                    OP_MOV, OP_IN:                         state_d = S_E1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: state_d = S_E1;
                    OP_HALT:                               state_d = S_HALT;
`ifdef CALL_RET_EN
                    OP_CALL:                               state_d = S_O1;
                    OP_RET:                                state_d = S_E1;
`endif
                    default: state_d = HALT_ON_ILLEGAL ? S_HALT : S_F1;
                endcase
            end
            S_O1: state_d = S_O2;
            S_O2: begin
                case (opcode)
                    OP_LD, OP_ST: state_d = S_E1;
`ifdef CALL_RET_EN
                    OP_CALL:      state_d = S_E1;
`endif
                    default:      state_d = S_F1;
                endcase
            end
            S_E1: begin
                if (is_alu_op(opcode) || opcode == OP_IN)
                    state_d = S_E2;
`ifdef CALL_RET_EN
                else if (opcode == OP_CALL || opcode == OP_RET)
                    state_d = S_E2;
`endif
                else
                    state_d = S_F1;
            end
            S_E2: begin
                if (is_alu_op(opcode)) zflag_d = alu_flags[FLAG_ZERO];
`ifdef CALL_RET_EN
                state_d = (opcode == OP_CALL) ? S_E3 : S_F1;
`else
                state_d = S_F1;
`endif
            end
            S_E3:    state_d = S_E4;
            S_E4:    state_d = S_F1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_F1;
        endcase
    end

    cu_decode u_decode (
        .state  (state_q),
        .opcode (opcode),
        .rd     (ir_out[3:2]),
        .rs     (ir_out[1:0]),
        .zflag  (zflag_q),
        .ctrl   (ctrl)
    );

    // Reset forces S_F1, whose decode is non-zero; gate so outputs read 0 while rst is high.
    assign ctrl_out = rst ? '0 : ctrl;

    assign {load_R3, load_R2, load_R1, load_R0} = ctrl_out.load_r;
    assign gprf_sel_read  = ctrl_out.sel_read;
    assign gprf_sel_write = ctrl_out.sel_write;
    assign load_PC        = ctrl_out.load_pc;
    assign inc_PC         = ctrl_out.inc_pc;
    assign load_IR        = ctrl_out.load_ir;
    assign load_Add_R     = ctrl_out.load_add_r;
    assign load_Reg_Y     = ctrl_out.load_reg_y;
    assign load_Reg_Z     = ctrl_out.load_reg_z;
    assign load_isr1      = ctrl_out.load_isr1;
    assign load_isr2      = ctrl_out.load_isr2;
    assign load_argreg1   = ctrl_out.load_argreg1;
    assign load_argreg2   = ctrl_out.load_argreg2;
    assign inc_SP         = ctrl_out.inc_sp;
    assign dec_SP         = ctrl_out.dec_sp;
    assign load_SP        = ctrl_out.load_sp;
    assign alu_select     = ctrl_out.alu_select;
    assign Mux_1_sel      = ctrl_out.mux_1_sel;
    assign Mux_2_sel      = ctrl_out.mux_2_sel;
    assign mem_write      = ctrl_out.mem_write;
    assign halted         = ctrl_out.halted;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle FSM sequencer that drives every control input of the processor datapath.
- Consumes the datapath's IR output and ALU flags, and produces the register loads, mux selects, ALU op, PC/SP strobes and RAM write.
- Sits beside the datapath at the top level. Memory is async-read RAM addressed by Add_R.

Parameters:
HALT_ON_ILLEGAL, 1, 1 = undefined opcode enters S_HALT; 0 = undefined opcode executes as NOP.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
ir_out  in  8  instruction register contents: [7:4] opcode, [3:2] rd, [1:0] rs
alu_flags  in  8  combinational ALU flags: bit0 zero, bit1 carry
load_R0..load_R3  out  1 each  GPR write enables, one-hot from rd
gprf_sel_read  out  2  GPR read select
gprf_sel_write  out  2  GPR write select (= rd)
load_PC, inc_PC, load_IR, load_Add_R, load_Reg_Y, load_Reg_Z  out  1 each  datapath strobes
load_isr1, load_isr2, load_argreg1, load_argreg2  out  1 each  auxiliary register loads
inc_SP, dec_SP, load_SP  out  1 each  stack pointer strobes
alu_select  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT
Mux_1_sel  out  3  0 GPR, 1 isr1, 2 isr2, 3 argreg1, 4 argreg2, 5 PC, 6 IR, 7 SP
Mux_2_sel  out  2  0 ALU, 1 Bus_1, 2 data_ram, 3 zero
mem_write  out  1  RAM write strobe; data is Bus_1
halted  out  1  high while in S_HALT

Behaviour:
- Reset: asynchronous, active-high. While rst=1, all outputs are 0, state = S_F1, and the internal zflag = 0.
- Outputs are combinational from the state register plus the latched IR. Any strobe not listed for a state is 0.
- inc_PC and load_PC are never asserted together; inc_SP and dec_SP are never asserted together.
- Fetch sequence:
  - S_F1: Mux_1=5, Mux_2=1, load_Add_R, inc_PC.
  - S_F2: Mux_2=2, load_IR.
  - S_DEC: no strobes; branch on opcode.
- Operand fetch (two-byte instructions):
  - S_O1: same outputs as S_F1.
  - S_O2: Mux_2=2; the destination depends on the opcode.
- Opcodes:
  - 0 NOP: DEC -> F1.
  - 1 LDI rd,#imm: O1, O2 loads rd -> F1.
  - 2 LD rd,[a]: O1, O2 load_Add_R, E1 Mux_2=2 load rd -> F1.
  - 3 ST rs,[a]: O1, O2 load_Add_R, E1 Mux_1=0 sel_read=rs mem_write -> F1.
  - 4 MOV rd,rs: E1 Mux_1=0 sel_read=rs Mux_2=1 load rd.
  - 5-9 ADD/SUB/AND/OR/NOT rd,rs:
    - E1: sel_read=rd, Mux_1=0, Mux_2=1, load_Reg_Y.
    - E2: sel_read=rs, alu_select, Mux_2=0, load rd, load_Reg_Z; zflag <= alu_flags[0].
  - A JMP a: O1, O2 load_PC.
  - B JZ a: O1, O2 load_PC only if zflag=1. When not taken, PC already points past the operand.
  - C IN rd: E1 load_isr1 if rs[0]=0, else load_isr2. E2 Mux_1=1 or 2, Mux_2=1, load rd.
  - F HALT: S_HALT, absorbing; exit only by rst.
- Only ALU ops update zflag. LD, MOV and LDI leave zflag unchanged.
- Cycle counts (F1 to next F1):
  - 3 cycles: NOP
  - 4 cycles: MOV
  - 5 cycles: LDI, JMP, JZ, IN, ALU ops
  - 6 cycles: LD, ST
- Reset mid-instruction aborts immediately; there is no partial write after rst rises.
- PC wraps 8'hFF -> 8'h00 in the datapath; the control unit ignores the wrap.

Optional Feature:
Macro CALL_RET_EN.
- When defined:
  - D CALL a: O1, O2 load_argreg1; E1 dec_SP; E2 Mux_1=7 Mux_2=1 load_Add_R; E3 Mux_1=5 mem_write; E4 Mux_1=3 Mux_2=1 load_PC.
  - E RET: E1 Mux_1=7 Mux_2=1 load_Add_R inc_SP; E2 Mux_2=2 load_PC.
- When undefined: D and E are undefined opcodes, handled per HALT_ON_ILLEGAL. inc_SP, dec_SP and load_SP are tied 0.

Decomposition:
- Package cpu_pkg holds: opcode constants, state enum, alu_select codes, Mux_1/Mux_2 select codes, flag bit indices.
- One sub-module, cu_decode: purely combinational; maps (state, opcode, rd, rs, zflag) to the control-word outputs.
- The top of control_unit holds the state register and zflag only.

Test Plan:
- Reset then RAM[0]=8'h1C (LDI R3), RAM[1]=8'h5A: R3=0x5A after 5 cycles; load_R3 pulses exactly once; PC=2.
- ADD R0,R1 with R0=0xFF, R1=0x01: R0=0x00, zflag=1. A following JZ 0x40 loads PC=0x40.
- JZ 0x40 with zflag=0: PC=prior+2; load_PC is never asserted.
- ST R2,[0x80] with R2=0x33: mem_write high for exactly 1 cycle with Add_R=0x80 and Bus_1=0x33.
- Opcode F: halted=1 from the cycle after S_DEC, and all strobes stay 0. Asserting rst mid-LD (in O2) forces all outputs to 0 asynchronously; after release, fetch restarts.
- With CALL_RET_EN: CALL 0x20 at PC=0x10, SP=0xFF: RAM[0xFE]=0x12, PC=0x20; RET restores PC=0x12, SP=0xFF.
